// File: rtl/vga_fb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_cmd_ctrl
// Description : Frame-buffer command controller. Turns the UART byte stream
//               into pixel writes for the back buffer, address syncs and
//               buffer-swap requests. A swap is held until the next
//               vertical-blank start and is then acknowledged on the UART
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_cmd_ctrl #(
  parameter int         H_RES    = 320,
  parameter int         V_RES    = 240,
  parameter int         ADDR_W   = 17,
  parameter logic [7:0] ACK_BYTE = 8'h81
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              vblank_start,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              wr_en,
  output logic              wr_buf,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_data,
  output logic              front_sel,
  output logic              swap_pending,
  output logic [ADDR_W-1:0] addr_count,
  output logic              drop_err
);

  // Number of pixels in one frame; addr_count saturates here instead of wrapping.
  localparam logic [ADDR_W:0] c_NPIX = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_SWAP_WAIT = 2'd1;
  localparam logic [1:0] c_ST_ACK       = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              r_front_sel;
  logic [ADDR_W-1:0] r_addr_count;
  logic              r_drop_err;
  logic              r_wr_en;
  logic              r_wr_buf;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [5:0]        r_wr_data;

  logic              w_is_pixel;
  logic              w_is_sync;
  logic              w_is_swap;
  logic              w_in_space;
  logic              w_pix_accept;
  logic              w_pix_drop;
  logic              w_swap_done;

  // Byte classification and pixel accept/drop decisions (pre-edge state).
  assign w_is_pixel   = rx_valid & ~rx_data[7];
  assign w_is_sync    = rx_valid & (rx_data == 8'h80);
  assign w_is_swap    = rx_valid & (rx_data == 8'h81);
  assign w_in_space   = ({1'b0, r_addr_count} < c_NPIX);
  // Pixels are refused while a swap waits: that buffer is about to be shown.
  assign w_pix_accept = w_is_pixel & (r_state != c_ST_SWAP_WAIT) & w_in_space;
  assign w_pix_drop   = w_is_pixel & ~w_pix_accept;
  assign w_swap_done  = (r_state == c_ST_SWAP_WAIT) & vblank_start;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic: swap byte arms, vblank completes, tx_ready releases ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:      if (w_is_swap)    w_state_nxt = c_ST_SWAP_WAIT;
      c_ST_SWAP_WAIT: if (vblank_start) w_state_nxt = c_ST_ACK;
      c_ST_ACK:       if (tx_ready)     w_state_nxt = c_ST_IDLE;
      default:                          w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs: ack byte presented for the whole ACK state, pending flag in SWAP_WAIT.
  always_comb begin
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    swap_pending = 1'b0;
    case (r_state)
      c_ST_SWAP_WAIT: swap_pending = 1'b1;
      c_ST_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
      end
      default: ;
    endcase
  end

  // Datapath: write pipeline register, pixel address counter, drop flag, front buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en      <= 1'b0;
      r_wr_buf     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_addr_count <= '0;
      r_drop_err   <= 1'b0;
      r_front_sel  <= 1'b0;
    end else begin
      r_wr_en <= w_pix_accept;
      if (w_pix_accept) begin
        r_wr_addr <= r_addr_count;
        r_wr_data <= rx_data[5:0];
        r_wr_buf  <= ~r_front_sel;
      end

      if (w_is_sync || w_swap_done) r_addr_count <= '0;
      else if (w_pix_accept)        r_addr_count <= r_addr_count + c_ADDR_ONE;

      if (w_is_sync)       r_drop_err <= 1'b0;
      else if (w_pix_drop) r_drop_err <= 1'b1;

      if (w_swap_done) r_front_sel <= ~r_front_sel;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_buf     = r_wr_buf;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign front_sel  = r_front_sel;
  assign addr_count = r_addr_count;
  assign drop_err   = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_fb_cmd_ctrl
// Description : Self-checking bench for vga_fb_cmd_ctrl. A full-size instance
//               and a 4x1 instance share stimulus; a frame-level reference
//               model predicts every cycle of the selected instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_cmd_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       vblank_start;
  logic       tx_ready;

  // full-size instance
  logic        tx_valid, wr_en, wr_buf, front_sel, swap_pending, drop_err;
  logic [7:0]  tx_data;
  logic [16:0] wr_addr, addr_count;
  logic [5:0]  wr_data;

  // 4x1 instance used for the overflow boundary
  logic        s_tx_valid, s_wr_en, s_wr_buf, s_front_sel, s_swap_pending, s_drop_err;
  logic [7:0]  s_tx_data;
  logic [2:0]  s_wr_addr, s_addr_count;
  logic [5:0]  s_wr_data;

  vga_fb_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .vblank_start(vblank_start), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .wr_en(wr_en), .wr_buf(wr_buf),
    .wr_addr(wr_addr), .wr_data(wr_data), .front_sel(front_sel),
    .swap_pending(swap_pending), .addr_count(addr_count), .drop_err(drop_err)
  );

  vga_fb_cmd_ctrl #(.H_RES(4), .V_RES(1), .ADDR_W(3)) dut_small (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .vblank_start(vblank_start), .tx_ready(tx_ready),
    .tx_valid(s_tx_valid), .tx_data(s_tx_data), .wr_en(s_wr_en), .wr_buf(s_wr_buf),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .front_sel(s_front_sel),
    .swap_pending(s_swap_pending), .addr_count(s_addr_count), .drop_err(s_drop_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: frame-level view of the controller.
  bit          sel;          // 0: full-size instance, 1: 4x1 instance
  int          m_npix;
  int          m_addr;
  bit          m_front, m_pending, m_acking, m_drop;
  bit          e_wr_en, e_wr_buf;
  logic [16:0] e_wr_addr;
  logic [5:0]  e_wr_data;
  logic [53:0] obs;

  // Packs one observation; write fields shown only for an expected write, tx_data only while acking.
  function automatic logic [53:0] pack(input bit mw, input bit mt, input bit we, input bit wb,
                                       input logic [16:0] wa, input logic [5:0] wd, input bit fs,
                                       input bit sp, input logic [16:0] ac, input bit de,
                                       input bit tv, input logic [7:0] td);
    return {we, mw ? wb : 1'b0, mw ? wa : 17'd0, mw ? wd : 6'd0, fs, sp, ac, de, tv,
            mt ? td : 8'd0};
  endfunction

  function automatic logic [53:0] expv();
    return pack(e_wr_en, m_acking, e_wr_en, e_wr_buf, e_wr_addr, e_wr_data, m_front,
                m_pending, m_addr[16:0], m_drop, m_acking, 8'h81);
  endfunction

  task automatic model_clear();
    m_addr = 0; m_front = 0; m_pending = 0; m_acking = 0; m_drop = 0;
    e_wr_en = 0; e_wr_buf = 0; e_wr_addr = '0; e_wr_data = '0;
    m_npix = sel ? 4 : 320 * 240;
  endtask

  // One clock: drive inputs, advance the model on the edge, sample outputs 1ns later.
  task automatic step(input bit v, input logic [7:0] d, input bit vb, input bit tr);
    bit pend0, ack0;
    rx_valid = v; rx_data = d; vblank_start = vb; tx_ready = tr;
    @(posedge clk);
    pend0 = m_pending; ack0 = m_acking; e_wr_en = 0;
    if (v) begin
      if (!d[7]) begin
        if (!pend0 && m_addr < m_npix) begin
          e_wr_en = 1; e_wr_addr = m_addr[16:0]; e_wr_data = d[5:0]; e_wr_buf = !m_front;
          m_addr++;
        end else m_drop = 1;
      end else if (d == 8'h80) begin
        m_addr = 0; m_drop = 0;
      end else if (d == 8'h81 && !pend0 && !ack0) m_pending = 1;
    end
    if (ack0 && tr) m_acking = 0;
    if (pend0 && vb) begin
      m_front = !m_front; m_pending = 0; m_addr = 0; m_acking = 1;
    end
    #1;
    if (sel)
      obs = pack(e_wr_en, m_acking, s_wr_en, s_wr_buf, {14'd0, s_wr_addr}, s_wr_data,
                 s_front_sel, s_swap_pending, {14'd0, s_addr_count}, s_drop_err,
                 s_tx_valid, s_tx_data);
    else
      obs = pack(e_wr_en, m_acking, wr_en, wr_buf, wr_addr, wr_data, front_sel,
                 swap_pending, addr_count, drop_err, tx_valid, tx_data);
    @(negedge clk);
    rx_valid = 0; vblank_start = 0; tx_ready = 0;
  endtask

  task automatic reset_dut();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 0; rx_valid = 0; rx_data = 0; vblank_start = 0; tx_ready = 0;
    sel = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'($urandom); rx_data = 8'($urandom);
      vblank_start = 1'($urandom); tx_ready = 1'($urandom);
      @(posedge clk); #1;
      n_chk++;
      if ({tx_valid, tx_data, wr_en, wr_buf, wr_addr, wr_data, front_sel, swap_pending,
           addr_count, drop_err} !== '0 ||
          {s_tx_valid, s_tx_data, s_wr_en, s_wr_buf, s_wr_addr, s_wr_data, s_front_sel,
           s_swap_pending, s_addr_count, s_drop_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: outputs not all zero (front=%b addr=%0d tx_valid=%b wr_en=%b)",
                 i, front_sel, addr_count, tx_valid, wr_en);
      end
      @(negedge clk);
    end
    rx_valid = 0; vblank_start = 0; tx_ready = 0;
    rst = 1;
    model_clear();
    step(0, 8'h00, 0, 0);
    n_chk++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", obs, expv());
    end
    n_chk++;
    if (front_sel !== 1'b0 || addr_count !== 17'd0) begin
      n_fail++; $display("FAIL reset_values: front_sel=%b addr_count=%0d expected 0/0", front_sel, addr_count);
    end
  endtask

  task automatic test_pixel_writes();
    logic [7:0] seq [5];
    logic [5:0] want [5];
    seq  = '{8'h80, 8'h12, 8'h34, 8'h56, 8'h78};
    want = '{6'h00, 6'h12, 6'h34, 6'h16, 6'h38};
    for (int i = 0; i < 5; i++) begin
      step(1, seq[i], 0, 0);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL pixel_writes byte %0d: got %h expected %h", i, obs, expv());
      end
      if (i > 0) begin
        n_chk++;
        if (wr_en !== 1'b1 || wr_addr !== 17'(i - 1) || wr_data !== want[i] || wr_buf !== 1'b1) begin
          n_fail++;
          $display("FAIL pixel_write_%0d: wr_en=%b addr=%0d data=%h buf=%b expected 1/%0d/%h/1",
                   i, wr_en, wr_addr, wr_data, wr_buf, i - 1, want[i]);
        end
      end
    end
    step(0, 8'h00, 0, 0);
    n_chk++;
    if (wr_en !== 1'b0 || addr_count !== 17'd4) begin
      n_fail++; $display("FAIL pixel_count: wr_en=%b addr_count=%0d expected 0/4", wr_en, addr_count);
    end
  endtask

  task automatic test_swap();
    step(1, 8'h81, 0, 0);
    n_chk++;
    if (obs !== expv() || swap_pending !== 1'b1) begin
      n_fail++; $display("FAIL swap_request: got %h expected %h", obs, expv());
    end
    step(0, 8'h00, 1, 0);
    n_chk++;
    if (front_sel !== 1'b1 || addr_count !== 17'd0 || tx_valid !== 1'b1 || tx_data !== 8'h81 ||
        swap_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_vblank: front=%b addr=%0d tx_valid=%b tx_data=%h pend=%b expected 1/0/1/81/0",
               front_sel, addr_count, tx_valid, tx_data, swap_pending);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h00, 0, 0);
      n_chk++;
      if (obs !== expv() || tx_valid !== 1'b1 || tx_data !== 8'h81) begin
        n_fail++; $display("FAIL ack_hold cycle %0d: got %h expected %h", i, obs, expv());
      end
    end
    step(0, 8'h00, 0, 1);
    n_chk++;
    if (obs !== expv() || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_release: tx_valid=%b expected 0 (got %h expected %h)", tx_valid, obs, expv());
    end
    step(1, 8'h3F, 0, 0);
    n_chk++;
    if (wr_en !== 1'b1 || wr_buf !== 1'b0 || wr_addr !== 17'd0 || wr_data !== 6'h3F) begin
      n_fail++; $display("FAIL post_swap_write: wr_en=%b buf=%b addr=%0d data=%h expected 1/0/0/3f",
                         wr_en, wr_buf, wr_addr, wr_data);
    end
  endtask

  task automatic test_drop_swap_wait();
    logic [7:0] seq [3];
    seq = '{8'h81, 8'h3F, 8'h30};
    for (int i = 0; i < 3; i++) begin
      step(1, seq[i], 0, 0);
      n_chk++;
      if (obs !== expv() || wr_en !== 1'b0) begin
        n_fail++; $display("FAIL drop_swap_wait byte %0d: got %h expected %h", i, obs, expv());
      end
    end
    n_chk++;
    if (drop_err !== 1'b1) begin
      n_fail++; $display("FAIL drop_err_set: drop_err=%b expected 1", drop_err);
    end
    step(1, 8'h80, 0, 0);
    n_chk++;
    if (drop_err !== 1'b0 || swap_pending !== 1'b1) begin
      n_fail++; $display("FAIL sync_clears_drop: drop_err=%b pend=%b expected 0/1", drop_err, swap_pending);
    end
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    n_chk++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL drop_swap_finish: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_overflow();
    sel = 1;
    reset_dut();
    step(1, 8'h80, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom_range(0, 127)), 0, 0);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL overflow pixel %0d: got %h expected %h", i, obs, expv());
      end
    end
    n_chk++;
    if (s_wr_en !== 1'b0 || s_drop_err !== 1'b1 || s_addr_count !== 3'd4) begin
      n_fail++; $display("FAIL overflow_fifth: wr_en=%b drop_err=%b addr=%0d expected 0/1/4",
                         s_wr_en, s_drop_err, s_addr_count);
    end
    sel = 0;
    reset_dut();
  endtask

  task automatic test_collision_and_reset();
    step(1, 8'h81, 0, 0);
    step(1, 8'h12, 1, 0);
    n_chk++;
    if (obs !== expv() || wr_en !== 1'b0 || front_sel !== 1'b1 || tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL collision: wr_en=%b front=%b tx_valid=%b (got %h expected %h)",
                         wr_en, front_sel, tx_valid, obs, expv());
    end
    step(0, 8'h00, 0, 1);
    step(1, 8'h81, 0, 0);
    n_chk++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: pend=%b front=%b expected 1/1", swap_pending, front_sel);
    end
    rst = 0;
    #1;
    n_chk++;
    if (swap_pending !== 1'b0 || front_sel !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: pend=%b front=%b tx_valid=%b expected 0/0/0",
                         swap_pending, front_sel, tx_valid);
    end
    @(negedge clk);
    rst = 1;
    model_clear();
  endtask

  task automatic test_random(input bit which, input int n);
    int r;
    logic [7:0] b;
    sel = which;
    reset_dut();
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      b = 8'($urandom_range(0, 127));
      else if (r < 76) b = 8'h80;
      else if (r < 88) b = 8'h81;
      else             b = 8'($urandom_range(130, 255));
      step(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 9) == 0), 1'($urandom));
      n_chk++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL random sel=%0d step %0d: got %h expected %h", which, i, obs, expv());
      end
    end
    sel = 0;
    reset_dut();
  endtask

  initial begin
    test_reset();
    test_pixel_writes();
    test_swap();
    test_drop_swap_wait();
    test_overflow();
    test_collision_and_reset();
    test_random(0, 400);
    test_random(1, 300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
